// File: rtl/kairo_reg_access.sv
// kairo_reg_access: debug read/write sequencer for the register file AR port; write-verify readback via KAIRO_REG_ACCESS_VERIFY_EN.
// Latency from accept: write 2 (4 with verify), read 3, not-halted 1; one command in flight, response held until RSP_READY.
module kairo_reg_access #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            HALTED,
  input  logic            CMD_VALID,
  output logic            CMD_READY,
  input  logic            CMD_WR,
  input  logic [AW-1:0]   CMD_ADDR,
  input  logic [XLEN-1:0] CMD_WDATA,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [XLEN-1:0] RSP_RDATA,
  output logic [1:0]      RSP_ERR,
  output logic            AR_EN,
  output logic            AR_WR,
  output logic [AW-1:0]   AR_AD,
  output logic [XLEN-1:0] AR_DI,
  input  logic [XLEN-1:0] AR_DO
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE,
    RESP
`ifdef KAIRO_REG_ACCESS_VERIFY_EN
    ,
    VREAD,
    VCAP
`endif
  } state_e;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_HALT = 2'd1;
`ifdef KAIRO_REG_ACCESS_VERIFY_EN
  localparam logic [1:0] ERR_VERIFY = 2'd2;
`endif

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic              ar_en;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          addr_d  = CMD_ADDR;
          wdata_d = CMD_WDATA;
          rdata_d = '0;
          err_d   = ERR_OK;
          // HALTED is only looked at here; a later drop does not abort the access.
          if (!HALTED) begin
            err_d   = ERR_HALT;
            state_d = RESP;
          end else if (CMD_WR) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
`ifdef KAIRO_REG_ACCESS_VERIFY_EN
        state_d = VREAD;
`else
        state_d = RESP;
`endif
      end
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        // AR_DO carries the data of the previous cycle's AR read.
        rdata_d = AR_DO;
        state_d = RESP;
      end
`ifdef KAIRO_REG_ACCESS_VERIFY_EN
      VREAD:   state_d = VCAP;
      VCAP: begin
        // x0 discards writes, so its readback is never compared.
        if ((addr_q != '0) && (AR_DO != wdata_q)) begin
          err_d = ERR_VERIFY;
        end
        state_d = RESP;
      end
`endif
      RESP: begin
        if (RSP_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef KAIRO_REG_ACCESS_VERIFY_EN
  assign ar_en = (state_q == WRITE) || (state_q == READ) || (state_q == VREAD);
`else
  assign ar_en = (state_q == WRITE) || (state_q == READ);
`endif

  assign AR_EN     = ar_en;
  assign AR_WR     = (state_q == WRITE);
  assign AR_AD     = ar_en ? addr_q : '0;
  assign AR_DI     = (state_q == WRITE) ? wdata_q : '0;
  assign CMD_READY = (state_q == IDLE);
  assign RSP_VALID = (state_q == RESP);
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_kairo_reg_access.sv
// Randomized scoreboard bench for kairo_reg_access with a behavioural register-file model.
// Build with KAIRO_REG_ACCESS_VERIFY_EN defined to also cover write verification.
module tb_kairo_reg_access;

`ifdef KAIRO_REG_ACCESS_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic        CLK, RST, HALTED;
  logic        CMD_VALID, CMD_READY, CMD_WR;
  logic [4:0]  CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID, RSP_READY;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_ERR;
  logic        AR_EN, AR_WR;
  logic [4:0]  AR_AD;
  logic [31:0] AR_DI, AR_DO;

  kairo_reg_access #(.XLEN(32), .AW(5)) dut (
    .CLK(CLK), .RST(RST), .HALTED(HALTED),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .AR_EN(AR_EN), .AR_WR(AR_WR), .AR_AD(AR_AD), .AR_DI(AR_DI), .AR_DO(AR_DO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int ncyc = 0;
  always @(posedge CLK) ncyc++;

  int total = 0;
  int bad   = 0;

  // Register file: x0 reads as zero and ignores writes; optional bit-0 fault on x7.
  logic [31:0] rf [32];
  logic        corrupt7 = 1'b0;
  always @(posedge CLK) begin
    if (AR_EN && AR_WR && AR_AD != 5'd0)
      rf[AR_AD] <= (corrupt7 && AR_AD == 5'd7) ? (AR_DI ^ 32'd1) : AR_DI;
    if (AR_EN && !AR_WR)
      AR_DO <= (AR_AD == 5'd0) ? 32'd0 : rf[AR_AD];
  end

  // Reference view of the architectural registers
  logic [31:0] ref_regs [32];

  typedef struct {
    int          acc;
    int          lat;
    logic        ok;
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t sb_q[$];

  logic rdy_low  = 1'b0;
  logic rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin
    RSP_READY = 1'b0;
    forever begin
      @(posedge CLK); #1;
      RSP_READY = rdy_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: compares every cycle against the oldest outstanding command.
  initial begin
    exp_t e;
    int   off;
    logic en, wr_e;
    forever begin
      @(negedge CLK); #1;
      if (RST) continue;
      if (sb_q.size() == 0) begin
        chk("idle_ar_en", 32'(AR_EN), 32'd0);
        chk("idle_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("idle_cmd_ready", 32'(CMD_READY), 32'd1);
      end else begin
        e    = sb_q[0];
        off  = ncyc - e.acc;
        en   = 1'b0;
        wr_e = 1'b0;
        if (e.ok) begin
          if (e.wr) begin
            if (off == 1) begin en = 1'b1; wr_e = 1'b1; end
            if (VER && off == 2) en = 1'b1;
          end else if (off == 1) begin
            en = 1'b1;
          end
        end
        chk("ar_en", 32'(AR_EN), 32'(en));
        if (en) begin
          chk("ar_wr", 32'(AR_WR), 32'(wr_e));
          chk("ar_ad", 32'(AR_AD), 32'(e.a));
          if (wr_e) chk("ar_di", AR_DI, e.d);
        end
        chk("cmd_ready", 32'(CMD_READY), 32'(off == 0));
        chk("rsp_valid", 32'(RSP_VALID), 32'(off >= e.lat));
        if (RSP_VALID) begin
          chk("rsp_rdata", RSP_RDATA, e.rdata);
          chk("rsp_err", 32'(RSP_ERR), 32'(e.err));
          if (RSP_READY) void'(sb_q.pop_front());
        end else if (off > 60) begin
          total++; bad++;
          $display("FAIL rsp_timeout: no response after %0d cycles, required by %0d", off, e.lat);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [4:0] a, input logic [31:0] d, input logic h);
    exp_t e;
    bit   ok = 1'b0;
    @(posedge CLK); #1;
    CMD_VALID = 1'b1; CMD_WR = wr; CMD_ADDR = a; CMD_WDATA = d; HALTED = h;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (CMD_READY) begin
        ok      = 1'b1;
        e.acc   = ncyc;
        e.ok    = h;
        e.wr    = wr;
        e.a     = a;
        e.d     = d;
        e.rdata = 32'd0;
        e.err   = 2'd0;
        if (!h) begin
          e.lat = 1;
          e.err = 2'd1;
        end else if (wr) begin
          e.lat = VER ? 4 : 2;
          if (a != 5'd0) begin
            ref_regs[a] = (corrupt7 && a == 5'd7) ? (d ^ 32'd1) : d;
            if (VER && ref_regs[a] != d) e.err = 2'd2;
          end
        end else begin
          e.lat   = 3;
          e.rdata = (a == 5'd0) ? 32'd0 : ref_regs[a];
        end
        sb_q.push_back(e);
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: CMD_READY stayed 0, required 1");
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    CMD_WR    = 1'($urandom_range(0, 1));
    CMD_ADDR  = 5'($urandom);
    CMD_WDATA = $urandom;
    HALTED    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i]       = 32'd0;
      ref_regs[i] = 32'd0;
    end
    AR_DO = 32'd0;
    RST = 1'b1; HALTED = 1'b0; CMD_VALID = 1'b0; CMD_WR = 1'b0;
    CMD_ADDR = 5'd0; CMD_WDATA = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ar_en", 32'(AR_EN), 32'd0);
    chk("rst_ar_wr", 32'(AR_WR), 32'd0);
    chk("rst_ar_ad", 32'(AR_AD), 32'd0);
    chk("rst_ar_di", AR_DI, 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
    chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
    RST = 1'b0;

    // Basic write/read, not-halted error, x0 behaviour
    issue(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 5'd5, 32'd0, 1'b1);
    wait_idle();
    issue(1'b0, 5'd3, 32'd0, 1'b0);
    wait_idle();
    issue(1'b1, 5'd0, 32'h12345678, 1'b1);
    issue(1'b0, 5'd0, 32'd0, 1'b1);
    wait_idle();

    // Response backpressure with a second command waiting
    rdy_low = 1'b1;
    issue(1'b0, 5'd5, 32'd0, 1'b1);
    fork
      begin
        for (int i = 0; i < 20 && !RSP_VALID; i++) @(negedge CLK);
        repeat (5) @(posedge CLK);
        #2 rdy_low = 1'b0;
      end
      issue(1'b1, 5'd6, 32'hCAFE0006, 1'b1);
    join
    wait_idle();

    // Reset while the read is on the AR port
    issue(1'b0, 5'd5, 32'd0, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_ar_en", 32'(AR_EN), 32'd0);
    chk("midrst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("midrst_cmd_ready", 32'(CMD_READY), 32'd1);
    sb_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (3) @(posedge CLK);

`ifdef KAIRO_REG_ACCESS_VERIFY_EN
    corrupt7 = 1'b1;
    issue(1'b1, 5'd7, 32'h0000000F, 1'b1);
    issue(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1);
    issue(1'b0, 5'd7, 32'd0, 1'b1);
    issue(1'b1, 5'd0, 32'h0BADF00D, 1'b1);
    wait_idle();
`endif

    rdy_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom,
            1'($urandom_range(0, 4) != 0));
    end
    wait_idle();
    rdy_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
